// File: rtl/digout_debug_pkg.sv
// Shared definitions for the digout debug link (transmitter and receiver).
package digout_debug_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned FRAME_LEN  = 64;
   localparam int unsigned START_BITS = 2;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      START2,
      DATA,
      TRAIL
   } state_t;

endpackage

// File: rtl/digout_rx_sync.sv
// Two-flop synchroniser for the asynchronous debug input pin.
module digout_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/digout_debug_rx.sv
// Receiver for the single-wire digout debug link: deframes, sequence-checks, tracks lock.
// Define DIGOUT_DEBUG_RX_SYNC_EN to put a 2-flop synchroniser in front of d.
module digout_debug_rx
   import digout_debug_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned MIN_IDLE    = 8,
   parameter int unsigned LOCK_FRAMES = 4,
   parameter int unsigned ERR_CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 d,
   output logic [DATA_W-1:0]    rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 seq_err,
   output logic                 locked,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int unsigned IDLE_W = $clog2(MIN_IDLE + 1);
   localparam int unsigned GOOD_W = $clog2(LOCK_FRAMES + 1);
   localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic d_s;

`ifdef DIGOUT_DEBUG_RX_SYNC_EN
   digout_rx_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .q     (d_s)
   );
`else
   assign d_s = d;
`endif

   state_t                state, state_nxt;
   logic [IDLE_W-1:0]     idle_cnt, idle_cnt_nxt;
   logic [BIT_W-1:0]      bit_idx, bit_idx_nxt;
   logic [DATA_W-1:0]     shreg, shreg_nxt;
   logic [DATA_W-1:0]     prev, prev_nxt;
   logic                  has_ref, has_ref_nxt;
   logic [GOOD_W-1:0]     good_cnt, good_cnt_nxt;
   logic [DATA_W-1:0]     rx_data_nxt;
   logic                  rx_valid_nxt, frame_err_nxt, seq_err_nxt, locked_nxt;
   logic [ERR_CNT_W-1:0]  err_cnt_nxt;
   logic                  accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idle_cnt  <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         prev      <= '0;
         has_ref   <= 1'b0;
         good_cnt  <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         seq_err   <= 1'b0;
         locked    <= 1'b0;
         err_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         idle_cnt  <= idle_cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shreg     <= shreg_nxt;
         prev      <= prev_nxt;
         has_ref   <= has_ref_nxt;
         good_cnt  <= good_cnt_nxt;
         rx_data   <= rx_data_nxt;
         rx_valid  <= rx_valid_nxt;
         frame_err <= frame_err_nxt;
         seq_err   <= seq_err_nxt;
         locked    <= locked_nxt;
         err_cnt   <= err_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      idle_cnt_nxt  = idle_cnt;
      bit_idx_nxt   = bit_idx;
      shreg_nxt     = shreg;
      prev_nxt      = prev;
      has_ref_nxt   = has_ref;
      good_cnt_nxt  = good_cnt;
      rx_data_nxt   = rx_data;
      rx_valid_nxt  = 1'b0;
      frame_err_nxt = 1'b0;
      seq_err_nxt   = 1'b0;
      err_cnt_nxt   = err_cnt;
      accept        = 1'b0;

      case (state)
         // Only a long enough run of zeros arms the detector, so payload ones never start a frame.
         IDLE: begin
            if (!d_s) begin
               if (idle_cnt >= IDLE_W'(MIN_IDLE - 1)) begin
                  idle_cnt_nxt = IDLE_W'(MIN_IDLE);
                  state_nxt    = ARMED;
               end else begin
                  idle_cnt_nxt = idle_cnt + IDLE_W'(1);
               end
            end else begin
               idle_cnt_nxt = '0;
            end
         end
         ARMED: begin
            if (d_s) state_nxt = START2;
         end
         START2: begin
            if (d_s) begin
               state_nxt   = DATA;
               bit_idx_nxt = '0;
            end else begin
               frame_err_nxt = 1'b1;
               state_nxt     = IDLE;
               idle_cnt_nxt  = IDLE_W'(1);
            end
         end
         DATA: begin
            shreg_nxt[bit_idx] = d_s;
            if (bit_idx == BIT_W'(DATA_W - 1)) state_nxt = TRAIL;
            else bit_idx_nxt = bit_idx + BIT_W'(1);
         end
         TRAIL: begin
            state_nxt = IDLE;
            if (!d_s) begin
               accept       = 1'b1;
               idle_cnt_nxt = IDLE_W'(1);
            end else begin
               frame_err_nxt = 1'b1;
               idle_cnt_nxt  = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (accept) begin
         rx_data_nxt  = shreg;
         rx_valid_nxt = 1'b1;
         prev_nxt     = shreg;
         has_ref_nxt  = 1'b1;
         if (has_ref && (shreg != prev + DATA_W'(1))) seq_err_nxt = 1'b1;
         else if (good_cnt != GOOD_W'(LOCK_FRAMES)) good_cnt_nxt = good_cnt + GOOD_W'(1);
      end

      if (frame_err_nxt) has_ref_nxt = 1'b0;

      if (frame_err_nxt || seq_err_nxt) begin
         good_cnt_nxt = '0;
         if (err_cnt != '1) err_cnt_nxt = err_cnt + ERR_CNT_W'(1);
      end

      locked_nxt = (good_cnt_nxt == GOOD_W'(LOCK_FRAMES));
   end

endmodule
